// File: rtl/x25519_arbiter_pkg.sv
// Shared types and constants for the X25519 engine arbiter.
package x25519_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

   localparam int X25519_WIDTH           = 256;
   localparam int DEFAULT_TIMEOUT_CYCLES = 2097151;
endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: first set request strictly after
// last_grant, wrapping modulo NUM_REQ.
module round_robin_picker #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] last_grant,
   output logic [ID_WIDTH-1:0] grant,
   output logic                any
);
   // Scan from the farthest candidate down so the nearest one is written last.
   always_comb begin
      grant = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[(int'(last_grant) + k) % NUM_REQ])
            grant = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      end
   end

   assign any = |req;
endmodule

// File: rtl/x25519_arbiter.sv
// Round-robin arbiter sharing one X25519 scalar-mult engine between NUM_REQ requesters.
// Optional BUSY watchdog enabled by `define X25519_ARBITER_TIMEOUT_EN.
module x25519_arbiter
   import x25519_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_WIDTH       = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*X25519_WIDTH-1:0] req_work_in,
   input  logic [NUM_REQ*X25519_WIDTH-1:0] req_e,
   output logic [NUM_REQ-1:0]              req_ack,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [ID_WIDTH-1:0]             rsp_id,
   output logic [X25519_WIDTH-1:0]         rsp_data,
   output logic                            rsp_err,
   output logic                            busy,
   output logic                            err_spurious,
   output logic                            crypt_en,
   output logic [X25519_WIDTH-1:0]         crypt_work_in,
   output logic [X25519_WIDTH-1:0]         crypt_e,
   input  logic                            crypt_out_valid,
   input  logic [X25519_WIDTH-1:0]         crypt_work_out
);
   state_t              state, state_next;
   logic [ID_WIDTH-1:0] last_grant;
   logic [ID_WIDTH-1:0] pick;
   logic                pick_any;
   logic                expire;

   round_robin_picker #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_picker (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (pick),
      .any        (pick_any)
   );

`ifdef X25519_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                cnt <= '0;
      else if (state != BUSY) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
   end

   // Fires during the last allowed BUSY cycle; the count would reach the limit at this edge.
   assign expire = (state == BUSY) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign expire = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pick_any) state_next = ISSUE;
         ISSUE:   state_next = BUSY;
         BUSY:    if (crypt_out_valid || expire) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant    <= ID_WIDTH'(NUM_REQ - 1);
         req_ack       <= '0;
         rsp_valid     <= '0;
         rsp_id        <= '0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
         busy          <= 1'b0;
         err_spurious  <= 1'b0;
         crypt_en      <= 1'b0;
         crypt_work_in <= '0;
         crypt_e       <= '0;
      end else begin
         req_ack   <= '0;
         rsp_valid <= '0;
         crypt_en  <= 1'b0;
         busy      <= (state_next != IDLE);
         if (crypt_out_valid && state != BUSY) err_spurious <= 1'b1;
         case (state)
            IDLE: if (pick_any) begin
               last_grant    <= pick;
               rsp_id        <= pick;
               crypt_work_in <= req_work_in[int'(pick)*X25519_WIDTH +: X25519_WIDTH];
               crypt_e       <= req_e[int'(pick)*X25519_WIDTH +: X25519_WIDTH];
               crypt_en      <= 1'b1;
               req_ack[pick] <= 1'b1;
            end
            // A result arriving on the expiry cycle takes precedence over the abort.
            BUSY: if (crypt_out_valid) begin
               rsp_data          <= crypt_work_out;
               rsp_err           <= 1'b0;
               rsp_valid[rsp_id] <= 1'b1;
            end else if (expire) begin
               rsp_data          <= '0;
               rsp_err           <= 1'b1;
               rsp_valid[rsp_id] <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_x25519_arbiter.sv
// Randomized self-checking bench for x25519_arbiter against a transaction-level model.
module tb_x25519_arbiter;
   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int W   = 256;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_work_in, req_e;
   logic [N-1:0]     req_ack, rsp_valid;
   logic [IDW-1:0]   rsp_id;
   logic [W-1:0]     rsp_data, crypt_work_in, crypt_e, crypt_work_out;
   logic             rsp_err, busy, err_spurious, crypt_en, crypt_out_valid;

   always #5 clk = ~clk;

   x25519_arbiter #(.NUM_REQ(N), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_work_in(req_work_in), .req_e(req_e),
      .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy), .err_spurious(err_spurious), .crypt_en(crypt_en),
      .crypt_work_in(crypt_work_in), .crypt_e(crypt_e), .crypt_out_valid(crypt_out_valid),
      .crypt_work_out(crypt_work_out)
   );

   int         n_chk = 0, n_err = 0;
   int         exp_last;
   bit         exp_spur;
   bit         use_fixed;
   logic [W-1:0] fixed_rsp;
   logic [W-1:0] op_w [N];
   logic [W-1:0] op_e [N];

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Stand-in for the scalar multiply: any fixed mixing of both operands will do.
   function automatic logic [W-1:0] eng_fn(input logic [W-1:0] w, input logic [W-1:0] e);
      return (w ^ {e[127:0], e[255:128]}) + W'(1);
   endfunction

   function automatic int rr_next(input logic [N-1:0] m, input int last);
      for (int k = 1; k <= N; k++)
         if (m[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic set_op(input int i, input logic [W-1:0] w, input logic [W-1:0] e);
      op_w[i] = w;
      op_e[i] = e;
      req_work_in[i*W +: W] = w;
      req_e[i*W +: W] = e;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      crypt_out_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_last = N - 1;
      exp_spur = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, W'(busy), W'(0));
      chk({tag, "_en"}, W'(crypt_en), W'(0));
      chk({tag, "_ack"}, W'(req_ack), W'(0));
      chk({tag, "_rspv"}, W'(rsp_valid), W'(0));
      chk({tag, "_rspid"}, W'(rsp_id), W'(0));
      chk({tag, "_rspdata"}, rsp_data, W'(0));
      chk({tag, "_rsperr"}, W'(rsp_err), W'(0));
      chk({tag, "_spur"}, W'(err_spurious), W'(0));
      chk({tag, "_cwork"}, crypt_work_in, W'(0));
      chk({tag, "_ce"}, crypt_e, W'(0));
   endtask

   task automatic churn();
      for (int i = 0; i < N; i++) begin
         int r = $urandom_range(0, 9);
         if (!req_valid[i] && r < 3) begin
            set_op(i, rand256(), rand256());
            req_valid[i] = 1'b1;
         end else if (req_valid[i] && r == 0) begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   // mode 0: drop after ack; 1: hold request; 2: random churn. Starts in IDLE with req_valid != 0.
   task automatic run_txn(input int delay, input int mode, output int got_g);
      int g;
      logic [W-1:0] cw, ce, res;
      g  = rr_next(req_valid, exp_last);
      cw = op_w[g];
      ce = op_e[g];
      @(posedge clk); #1;
      got_g = -1;
      for (int i = 0; i < N; i++) if (req_ack[i]) got_g = i;
      chk("grant_en", W'(crypt_en), W'(1));
      chk("grant_ack", W'(req_ack), W'(1 << g));
      chk("grant_work", crypt_work_in, cw);
      chk("grant_e", crypt_e, ce);
      chk("grant_id", W'(rsp_id), W'(g));
      chk("grant_busy", W'(busy), W'(1));
      exp_last = g;
      if (mode == 0) req_valid[g] = 1'b0;
      if (mode == 2) begin
         if ($urandom_range(0, 1) == 1) begin
            set_op(g, rand256(), rand256());
            req_valid[g] = 1'b1;
         end else begin
            req_valid[g] = 1'b0;
         end
      end
      @(posedge clk); #1;
      for (int c = 0; c < delay; c++) begin
         chk("busy_en", W'(crypt_en), W'(0));
         chk("busy_rspv", W'(rsp_valid), W'(0));
         chk("busy_hold", crypt_work_in, cw);
         if (mode == 2) churn();
         @(posedge clk); #1;
      end
      chk("busy_en", W'(crypt_en), W'(0));
      chk("busy_ack", W'(req_ack), W'(0));
      res = use_fixed ? fixed_rsp : eng_fn(cw, ce);
      crypt_work_out  = use_fixed ? fixed_rsp : eng_fn(crypt_work_in, crypt_e);
      crypt_out_valid = 1'b1;
      @(posedge clk); #1;
      crypt_out_valid = 1'b0;
      chk("rsp_valid", W'(rsp_valid), W'(1 << g));
      chk("rsp_id", W'(rsp_id), W'(g));
      chk("rsp_data", rsp_data, res);
      chk("rsp_err", W'(rsp_err), W'(0));
      chk("rsp_spur", W'(err_spurious), W'(exp_spur));
      chk("rsp_en", W'(crypt_en), W'(0));
      @(posedge clk); #1;
      chk("post_rspv", W'(rsp_valid), W'(0));
      chk("post_busy", W'(busy), W'(0));
      chk("post_hold", rsp_data, res);
   endtask

   initial begin
      int got;
      int order [6] = '{0, 1, 2, 3, 0, 1};
      req_work_in = '0;
      req_e = '0;
      crypt_work_out = '0;
      use_fixed = 1'b0;
      fixed_rsp = {16'hDEAD, 224'h0, 16'hBEEF};
      for (int i = 0; i < N; i++) set_op(i, '0, '0);
      do_reset();
      chk_idle_outputs("reset");

      // Fairness: everyone requesting continuously
      for (int i = 0; i < N; i++) set_op(i, W'(100 + i), W'(200 + i));
      req_valid = '1;
      for (int k = 0; k < 6; k++) begin
         run_txn($urandom_range(0, 4), 1, got);
         chk("fair_order", W'(got), W'(order[k]));
      end

      // Single request from requester 2 with a fixed engine result
      req_valid = 4'b0100;
      set_op(2, W'(9), {32{8'h5A}});
      use_fixed = 1'b1;
      run_txn(18, 0, got);
      use_fixed = 1'b0;

      // Spurious completion while idle
      crypt_work_out = rand256();
      crypt_out_valid = 1'b1;
      @(posedge clk); #1;
      crypt_out_valid = 1'b0;
      exp_spur = 1'b1;
      chk("spur_flag", W'(err_spurious), W'(1));
      chk("spur_rspv", W'(rsp_valid), W'(0));
      chk("spur_busy", W'(busy), W'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("spur_sticky", W'(err_spurious), W'(1));
      chk("spur_idle", W'(busy), W'(0));

      // Reset in the middle of BUSY
      set_op(3, rand256(), rand256());
      req_valid = 4'b1000;
      @(posedge clk); #1;
      chk("rstb_ack", W'(req_ack), W'(4'b1000));
      req_valid = '0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_idle_outputs("rst_async");
      @(posedge clk); #1;
      rst = 1'b0;
      exp_last = N - 1;
      exp_spur = 1'b0;
      crypt_work_out = rand256();
      crypt_out_valid = 1'b1;
      @(posedge clk); #1;
      crypt_out_valid = 1'b0;
      exp_spur = 1'b1;
      chk("late_rspv", W'(rsp_valid), W'(0));
      chk("late_spur", W'(err_spurious), W'(1));
      set_op(1, rand256(), rand256());
      req_valid = 4'b0010;
      run_txn(3, 0, got);
      chk("reissue_g", W'(got), W'(1));

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         if (req_valid == '0) begin
            int i = $urandom_range(0, N - 1);
            set_op(i, rand256(), rand256());
            req_valid[i] = 1'b1;
         end
         run_txn($urandom_range(0, 8), 2, got);
      end

`ifdef X25519_ARBITER_TIMEOUT_EN
      // Engine never answers: abort after 16 BUSY cycles
      do_reset();
      set_op(0, rand256(), rand256());
      req_valid = 4'b0001;
      @(posedge clk); #1;
      chk("to_ack", W'(req_ack), W'(1));
      req_valid = '0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         chk("to_wait", W'(rsp_valid), W'(0));
      end
      @(posedge clk); #1;
      chk("to_rspv", W'(rsp_valid), W'(1));
      chk("to_err", W'(rsp_err), W'(1));
      chk("to_data", rsp_data, W'(0));
      crypt_out_valid = 1'b1;
      @(posedge clk); #1;
      crypt_out_valid = 1'b0;
      chk("to_late_spur", W'(err_spurious), W'(1));
      // Result arriving on the expiry cycle wins
      req_valid = 4'b0001;
      @(posedge clk); #1;
      chk("toc_ack", W'(req_ack), W'(1));
      req_valid = '0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
      end
      crypt_work_out = rand256();
      crypt_out_valid = 1'b1;
      fixed_rsp = crypt_work_out;
      @(posedge clk); #1;
      crypt_out_valid = 1'b0;
      chk("toc_rspv", W'(rsp_valid), W'(1));
      chk("toc_err", W'(rsp_err), W'(0));
      chk("toc_data", rsp_data, fixed_rsp);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
